serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor built around the single-bit full_sub cell. It computes A − B − Bin one bit per clock, LSB first, and chains the borrow through a register. It sits directly upstream of the full_sub cell: it feeds that cell one operand bit pair per cycle and consumes its diff/bout. Control uses a start/busy/done handshake toward the issuing logic.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_sub.sv | 16 +
 rtl/serial_subtractor.sv | 122 ++++++++++++
 tb/tb_serial_subtractor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/full_sub.sv
// Single-bit full subtractor: diff = a - b - bin, bout = borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when a==b and a borrow is already pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b - bin), LSB first, borrow chained through a register.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH; one op per WIDTH+2 cycles.
// Backpressure: start is only honoured in IDLE; it is ignored while busy (RUN or DONE).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             brw_q,    brw_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             bout_q,   bout_d;

    logic             cell_diff;
    logic             cell_bout;
    logic [WIDTH-1:0] res_next;

    full_sub u_full_sub (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // Result shift register with the new diff bit entering at the MSB; the
    // shift/or form keeps WIDTH=1 legal (no empty slice).
    assign res_next = (res_sh_q >> 1) | (WIDTH'(cell_diff) << (WIDTH - 1));

    // Next-state logic: load on start in IDLE, shift one bit per RUN edge, publish on the last bit.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    brw_d    = bin;
                    cnt_d    = '0;
                    res_sh_d = '0;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next;
                brw_d    = cell_bout;
                if (cnt_q == CNT_LAST) begin
                    // Counter holds on the last bit so it never wraps.
                    diff_d  = res_next;
                    bout_d  = cell_bout;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    // busy spans RUN and DONE; done is the single DONE cycle.
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: drivers push expected results into per-DUT queues, monitors pop on done.
// Covers WIDTH=8 directed vectors (incl. ignored start, held start, async reset) and WIDTH=2 exhaustive.
// Monitors also check that diff/bout hold their last result while busy.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;

    // WIDTH=8 instance
    logic       rst8_n, s8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    // WIDTH=2 instance
    logic       rst2_n, s2, bin2, busy2, done2, bout2;
    logic [1:0] a2, b2, diff2;

    exp_t q8[$];
    exp_t q2[$];
    logic [7:0] last_d8;
    logic       last_b8;
    logic [1:0] last_d2;
    logic       last_b2;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(s8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start(s2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Scoreboard monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (!rst8_n) begin
            last_d8 = 8'h00;
            last_b8 = 1'b0;
        end else if (done8) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", {31'd0, done8}, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("diff8", {24'd0, diff8}, {24'd0, e.d});
                chk("bout8", {31'd0, bout8}, {31'd0, e.bo});
                chk("latency8", cyc - e.acc, 32'd8);
                last_d8 = e.d;
                last_b8 = e.bo;
            end
        end else if (busy8) begin
            chk("hold_diff8", {24'd0, diff8}, {24'd0, last_d8});
            chk("hold_bout8", {31'd0, bout8}, {31'd0, last_b8});
        end
    end

    // Scoreboard monitor for the WIDTH=2 instance.
    always @(negedge clk) begin
        if (!rst2_n) begin
            last_d2 = 2'b00;
            last_b2 = 1'b0;
        end else if (done2) begin
            if (q2.size() == 0) begin
                chk("unexpected_done2", {31'd0, done2}, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("diff2", {30'd0, diff2}, {24'd0, e.d});
                chk("bout2", {31'd0, bout2}, {31'd0, e.bo});
                chk("latency2", cyc - e.acc, 32'd2);
                last_d2 = e.d[1:0];
                last_b2 = e.bo;
            end
        end else if (busy2) begin
            chk("hold_diff2", {30'd0, diff2}, {30'd0, last_d2});
            chk("hold_bout2", {31'd0, bout2}, {31'd0, last_b2});
        end
    end

    task automatic wait_idle8();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy8) return;
        end
        chk("idle_timeout8", {31'd0, busy8}, 32'd0);
    endtask

    task automatic wait_idle2();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy2) return;
        end
        chk("idle_timeout2", {31'd0, busy2}, 32'd0);
    endtask

    // Issue one WIDTH=8 operation; returns just after the accept edge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                       input logic [7:0] d, input logic bo);
        exp_t e;
        wait_idle8();
        a8 = a; b8 = b; bin8 = bi; s8 = 1'b1;
        @(posedge clk);
        #1;
        s8 = 1'b0;
        a8 = ~a; b8 = ~b; bin8 = ~bi;
        chk("accept8", {31'd0, busy8}, 32'd1);
        e.d = d; e.bo = bo; e.acc = cyc;
        q8.push_back(e);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic bi,
                       input logic [1:0] d, input logic bo);
        exp_t e;
        wait_idle2();
        a2 = a; b2 = b; bin2 = bi; s2 = 1'b1;
        @(posedge clk);
        #1;
        s2 = 1'b0;
        a2 = ~a; b2 = ~b; bin2 = ~bi;
        chk("accept2", {31'd0, busy2}, 32'd1);
        e.d = {6'd0, d}; e.bo = bo; e.acc = cyc;
        q2.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int prev_acc;
        int accepts;
        logic prev_busy;

        rst8_n = 1'b0; rst2_n = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        s2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        #1;
        chk("rst_busy8", {31'd0, busy8}, 32'd0);
        chk("rst_done8", {31'd0, done8}, 32'd0);
        chk("rst_diff8", {24'd0, diff8}, 32'd0);
        chk("rst_bout8", {31'd0, bout8}, 32'd0);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);
        chk("rst_diff2", {30'd0, diff2}, 32'd0);
        #21;
        rst8_n = 1'b1; rst2_n = 1'b1;

        // Basic op, then a result-hold op (diff must stay 37 while busy).
        op8(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        op8(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1);
        // Borrow corner cases.
        op8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        op8(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        op8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);

        // Start pulse and operand changes during RUN are ignored.
        op8(8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0);
        repeat (3) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hAA; bin8 = 1'b1; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;

        // Held start: back-to-back operations every WIDTH+2 cycles.
        wait_idle8();
        a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; s8 = 1'b1;
        prev_busy = busy8;
        prev_acc = 0;
        accepts = 0;
        for (int i = 0; i < 40 && accepts < 3; i++) begin
            exp_t e;
            @(posedge clk);
            #1;
            if (busy8 && !prev_busy) begin
                e.d = 8'h22; e.bo = 1'b0; e.acc = cyc;
                q8.push_back(e);
                if (accepts > 0) chk("b2b_spacing8", cyc - prev_acc, 32'd10);
                prev_acc = cyc;
                accepts++;
            end
            prev_busy = busy8;
        end
        s8 = 1'b0;
        chk("b2b_accepts8", accepts, 32'd3);

        // Asynchronous reset between RUN edges 4 and 5 aborts the op.
        op8(8'h55, 8'h11, 1'b0, 8'h44, 1'b0);
        repeat (5) @(negedge clk);
        #2;
        rst8_n = 1'b0;
        #1;
        chk("arst_busy8", {31'd0, busy8}, 32'd0);
        chk("arst_done8", {31'd0, done8}, 32'd0);
        chk("arst_diff8", {24'd0, diff8}, 32'd0);
        chk("arst_bout8", {31'd0, bout8}, 32'd0);
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        #2;
        rst8_n = 1'b1;
        op8(8'hC8, 8'h64, 1'b0, 8'h64, 1'b0);
        wait_idle8();

        // WIDTH=2 exhaustive against an arithmetic model.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int bi = 0; bi < 2; bi++) begin
                    int r;
                    logic [1:0] av, bv, dv;
                    r = a - b - bi;
                    av = 2'(a); bv = 2'(b); dv = 2'(r & 3);
                    op2(av, bv, 1'(bi), dv, (a < b + bi));
                end
        wait_idle2();
        wait_idle8();
        repeat (4) @(negedge clk);
        chk("drain_q8", q8.size(), 32'd0);
        chk("drain_q2", q2.size(), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
